// File: rtl/id_ex_pkg.sv
// id_ex_pkg: shared definitions for the ID/EX control path.
//   - opcode/funct constants for the supported instruction subset
//   - alu_op and so_sel encodings
//   - bit positions inside the 17-bit control bundle
//   - the seven control words produced by the decoder
package id_ex_pkg;

    localparam int CW = 17;
    localparam int IW = 32;

    // Opcodes (instruction[31:26]) and the SPECIAL funct (instruction[5:0])
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LBU     = 6'b100100;
    localparam logic [5:0] OP_SB      = 6'b101000;
    localparam logic [5:0] FN_SUBU    = 6'b100011;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_SUB    = 4'b0001,
        ALU_PASS_B = 4'b0111
    } alu_op_e;

    typedef enum logic [2:0] {
        SO_RT      = 3'b000,
        SO_IMM_SE  = 3'b001,
        SO_IMM_HI  = 3'b010
    } so_sel_e;

    typedef enum logic [1:0] {
        MSZ_BYTE = 2'b00,
        MSZ_HALF = 2'b01,
        MSZ_WORD = 2'b10
    } mem_size_e;

    // Bundle bit positions
    localparam int B_ALU_OP_HI   = 16;
    localparam int B_ALU_OP_LO   = 13;
    localparam int B_SO_SEL_HI   = 12;
    localparam int B_SO_SEL_LO   = 10;
    localparam int B_LINK        = 9;
    localparam int B_JUMP        = 8;
    localparam int B_BRANCH      = 7;
    localparam int B_LOAD        = 6;
    localparam int B_MEM_SE      = 5;
    localparam int B_MEM_SIZE_HI = 4;
    localparam int B_MEM_SIZE_LO = 3;
    localparam int B_MEM_RW      = 2;
    localparam int B_MEM_EN      = 1;
    localparam int B_RF_EN       = 0;

    // Field order: alu_op, so_sel, link, jump, branch, load, mem_se,
    //              mem_size, mem_rw, mem_en, rf_en
    localparam logic [CW-1:0] CTRL_NONE  = '0;
    localparam logic [CW-1:0] CTRL_ADDIU =
        {ALU_ADD, SO_IMM_SE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MSZ_BYTE, 1'b0, 1'b0, 1'b1};
    localparam logic [CW-1:0] CTRL_LBU =
        {ALU_ADD, SO_IMM_SE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, MSZ_BYTE, 1'b0, 1'b1, 1'b1};
    localparam logic [CW-1:0] CTRL_SB =
        {ALU_ADD, SO_IMM_SE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MSZ_BYTE, 1'b1, 1'b1, 1'b0};
    localparam logic [CW-1:0] CTRL_BGTZ =
        {ALU_ADD, SO_RT,     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, MSZ_BYTE, 1'b0, 1'b0, 1'b0};
    localparam logic [CW-1:0] CTRL_JAL =
        {ALU_ADD, SO_RT,     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, MSZ_BYTE, 1'b0, 1'b0, 1'b1};
    localparam logic [CW-1:0] CTRL_LUI =
        {ALU_PASS_B, SO_IMM_HI, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MSZ_BYTE, 1'b0, 1'b0, 1'b1};
    localparam logic [CW-1:0] CTRL_SUBU =
        {ALU_SUB, SO_RT,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MSZ_BYTE, 1'b0, 1'b0, 1'b1};

endpackage

// File: rtl/id_ex_ctrl_decode.sv
// id_ex_ctrl_decode: combinational instruction -> control bundle decoder.
// Ports:
//   instr_i  [IW-1:0]  instruction from the IF/ID register
//   ctrl_o   [CW-1:0]  decoded control bundle; zero for anything unsupported
module id_ex_ctrl_decode
    import id_ex_pkg::*;
(
    input  logic [IW-1:0] instr_i,
    output logic [CW-1:0] ctrl_o
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = instr_i[31:26];
    assign funct  = instr_i[5:0];

    // Register/immediate fields are datapath-only; the decoder never looks at them.
    logic unused_fields;
    assign unused_fields = ^instr_i[25:6];

    always_comb begin
        ctrl_o = CTRL_NONE;
        case (opcode)
            OP_ADDIU:   ctrl_o = CTRL_ADDIU;
            OP_LBU:     ctrl_o = CTRL_LBU;
            OP_SB:      ctrl_o = CTRL_SB;
            OP_BGTZ:    ctrl_o = CTRL_BGTZ;
            OP_JAL:     ctrl_o = CTRL_JAL;
            OP_LUI:     ctrl_o = CTRL_LUI;
            OP_SPECIAL: ctrl_o = (funct == FN_SUBU) ? CTRL_SUBU : CTRL_NONE;
            default:    ctrl_o = CTRL_NONE;
        endcase
    end

endmodule

// File: rtl/id_ex_ctrl_path.sv
// id_ex_ctrl_path: control path of the ID and EX pipeline stages.
// Decodes the instruction, applies the hazard-bubble mux, and carries the
// bundle through the ID/EX and EX/MEM registers.
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low clear of both pipeline registers
//   instruction  [IW-1:0] instruction from IF/ID
//   S            1 forces a bubble (all-zero bundle) into the ID stage
//   id_ctrl      [CW-1:0] combinational ID-stage bundle
//   ex_ctrl      [CW-1:0] ID/EX register output
//   mem_ctrl     [CW-1:0] EX/MEM register output
module id_ex_ctrl_path
    import id_ex_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] instruction,
    input  logic          S,
    output logic [CW-1:0] id_ctrl,
    output logic [CW-1:0] ex_ctrl,
    output logic [CW-1:0] mem_ctrl
);

    logic [CW-1:0] dec_ctrl;
    logic [CW-1:0] ex_ctrl_d,  ex_ctrl_q;
    logic [CW-1:0] mem_ctrl_d, mem_ctrl_q;

    id_ex_ctrl_decode u_decode (
        .instr_i (instruction),
        .ctrl_o  (dec_ctrl)
    );

    assign id_ctrl    = S ? CTRL_NONE : dec_ctrl;
    assign ex_ctrl_d  = id_ctrl;
    assign mem_ctrl_d = ex_ctrl_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_ctrl_q  <= '0;
            mem_ctrl_q <= '0;
        end else begin
            ex_ctrl_q  <= ex_ctrl_d;
            mem_ctrl_q <= mem_ctrl_d;
        end
    end

    assign ex_ctrl  = ex_ctrl_q;
    assign mem_ctrl = mem_ctrl_q;

endmodule

// File: tb/tb_id_ex_ctrl_path.sv
module tb_id_ex_ctrl_path;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        S;
    logic [16:0] id_ctrl, ex_ctrl, mem_ctrl;

    int total = 0;
    int bad   = 0;

    // Reference state: what each pipeline register should hold
    logic [16:0] ex_exp, mem_exp;

    // Control word per supported opcode, written straight from the bundle table
    logic [16:0] op_tbl [bit [5:0]];

    id_ex_ctrl_path dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .S           (S),
        .id_ctrl     (id_ctrl),
        .ex_ctrl     (ex_ctrl),
        .mem_ctrl    (mem_ctrl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %05h want %05h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [16:0] model(input logic [31:0] ins, input logic s);
        bit [5:0] op;
        op = ins[31:26];
        if (s) return 17'h0;
        if (op == 6'b000000) return (ins[5:0] == 6'b100011) ? 17'h02001 : 17'h0;
        if (op_tbl.exists(op)) return op_tbl[op];
        return 17'h0;
    endfunction

    // One pipeline cycle: apply inputs, check ID, clock, check EX/MEM.
    // Entered and left at 1 time unit after a rising edge.
    task automatic step(input logic [31:0] ins, input logic s);
        logic [16:0] e;
        instruction = ins;
        S = s;
        e = model(ins, s);
        #1;
        chk("id_ctrl", id_ctrl, e);
        @(posedge clk);
        mem_exp = ex_exp;
        ex_exp  = e;
        #1;
        chk("ex_ctrl", ex_ctrl, ex_exp);
        chk("mem_ctrl", mem_ctrl, mem_exp);
    endtask

    logic [31:0] sweep [7];
    logic [16:0] sweep_exp [7];

    initial begin
        op_tbl[6'b001001] = 17'h00401;
        op_tbl[6'b100100] = 17'h00443;
        op_tbl[6'b101000] = 17'h00406;
        op_tbl[6'b000111] = 17'h00080;
        op_tbl[6'b000011] = 17'h00301;
        op_tbl[6'b001111] = 17'h0E801;

        sweep = '{32'h24010005, 32'h90220000, 32'h1C200003, 32'hA0220000,
                  32'h0C000010, 32'h3C011234, 32'h00221823};
        sweep_exp = '{17'h00401, 17'h00443, 17'h00080, 17'h00406,
                      17'h00301, 17'h0E801, 17'h02001};

        // 1. reset held for two cycles
        reset = 1'b0;
        instruction = 32'h24010005;
        S = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex", ex_ctrl, 17'h0);
        chk("rst_mem", mem_ctrl, 17'h0);
        chk("rst_id", id_ctrl, 17'h00401);
        ex_exp = '0;
        mem_exp = '0;
        reset = 1'b1;
        step(32'h24010005, 1'b0);
        chk("rel_ex1", ex_ctrl, 17'h00401);
        step(32'h24010005, 1'b0);
        chk("rel_mem2", mem_ctrl, 17'h00401);

        // 2/3. decode sweep with pipeline ordering
        for (int i = 0; i < 7; i++) begin
            instruction = sweep[i];
            S = 1'b0;
            #1;
            chk("sweep_id", id_ctrl, sweep_exp[i]);
            #1;
            step(sweep[i], 1'b0);
        end

        // 4. single-cycle bubble on SUBU
        step(32'h00221823, 1'b0);
        step(32'h00221823, 1'b0);
        step(32'h00221823, 1'b1);
        chk("bub_ex", ex_ctrl, 17'h0);
        chk("bub_mem_prev", mem_ctrl, 17'h02001);
        step(32'h00221823, 1'b0);
        chk("bub_mem", mem_ctrl, 17'h0);
        chk("bub_ex_next", ex_ctrl, 17'h02001);
        step(32'h00221823, 1'b0);
        chk("bub_mem_next", mem_ctrl, 17'h02001);

        // 5. NOP and unsupported SPECIAL funct
        step(32'h00000000, 1'b0);
        step(32'h00221821, 1'b0);

        // 6. async reset between edges while LUI sits in EX/MEM
        step(32'h3C011234, 1'b0);
        step(32'h24010005, 1'b0);
        chk("pre_rst_mem", mem_ctrl, 17'h0E801);
        #2;
        reset = 1'b0;
        #1;
        chk("async_ex", ex_ctrl, 17'h0);
        chk("async_mem", mem_ctrl, 17'h0);
        ex_exp = '0;
        mem_exp = '0;
        @(posedge clk);
        #1;
        chk("hold_ex", ex_ctrl, 17'h0);
        chk("hold_mem", mem_ctrl, 17'h0);
        reset = 1'b1;

        // Randomized stream with occasional bubbles and mid-cycle resets
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins;
            int k;
            k = $urandom_range(0, 9);
            ins = $urandom;
            case (k)
                0: ins[31:26] = 6'b001001;
                1: ins[31:26] = 6'b100100;
                2: ins[31:26] = 6'b101000;
                3: ins[31:26] = 6'b000111;
                4: ins[31:26] = 6'b000011;
                5: ins[31:26] = 6'b001111;
                6: begin ins[31:26] = 6'b000000; ins[5:0] = 6'b100011; end
                7: ins[31:26] = 6'b000000;
                default: ;
            endcase
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b0;
                #1;
                chk("rnd_rst_ex", ex_ctrl, 17'h0);
                chk("rnd_rst_mem", mem_ctrl, 17'h0);
                ex_exp = '0;
                mem_exp = '0;
                #1;
                reset = 1'b1;
                #1;
            end
            step(ins, $urandom_range(0, 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
